// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
//               Holds the fetch FSM state enum, mainMem access-size codes,
//               the burst length and the default program base address.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4
  } fetch_state_e;

  // mainMem access-size codes (words per burst: 1/4/8/16)
  localparam logic [1:0] ACC_1W  = 2'b00;
  localparam logic [1:0] ACC_4W  = 2'b01;
  localparam logic [1:0] ACC_8W  = 2'b10;
  localparam logic [1:0] ACC_16W = 2'b11;

  localparam int BURST_WORDS = 4;

  localparam logic [0:31] RESET_PC_DEFAULT = 32'h8002_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Fetch buffer holding {pc, insn} pairs. Synchronous flush,
//               simultaneous push/pop (also when full), occupancy output.
//               Head data reads as zero while empty.
// Ports       : clk_i   - clock
//               rst_ni  - asynchronous active-low reset
//               flush_i - drop all entries (wins over push and pop)
//               push_i  - write data_i (caller guarantees space)
//               data_i  - entry to write
//               pop_i   - consume head entry (ignored when empty)
//               data_o  - head entry
//               empty_o - no entries held
//               count_o - number of entries held
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/insn_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : insn_fetch_unit
// Description : Instruction fetch stage in front of mainMem. Owns the PC,
//               issues 4-word burst reads, buffers {pc, word} pairs and
//               hands them to decode over valid/ready. A redirect flushes
//               buffered and in-flight words and restarts at the new PC.
//               Big-endian [0:31] bit order throughout.
// Ports       : clock_i          - clock (posedge)
//               reset_n_i        - asynchronous active-low reset
//               mem_addr_o       - burst start address
//               mem_data_in_o    - write data, always zero
//               mem_data_out_i   - read data from mainMem
//               mem_acc_size_o   - access size, fixed 4-word burst
//               mem_wren_o       - write enable, always zero
//               mem_enable_o     - high from request through last burst word
//               mem_busy_i       - mainMem cannot accept a request
//               redirect_valid_i - restart fetch at redirect_pc_i
//               redirect_pc_i    - new PC (two LSBs ignored)
//               insn_valid_o     - insn_o/insn_pc_o valid
//               insn_ready_i     - decode accepts the word
//               insn_o           - instruction word
//               insn_pc_o        - address of insn_o
// Revision    : 1.0 - initial release
// ============================================================================
module insn_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [0:31] RESET_PC     = RESET_PC_DEFAULT,
  parameter int          READ_LATENCY = 2,   // must be >= 2
  parameter int          FIFO_DEPTH   = 8    // power of 2, >= 4
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  output logic [0:31] mem_addr_o,
  output logic [0:31] mem_data_in_o,
  input  logic [0:31] mem_data_out_i,
  output logic [1:0]  mem_acc_size_o,
  output logic        mem_wren_o,
  output logic        mem_enable_o,
  input  logic        mem_busy_i,
  input  logic        redirect_valid_i,
  input  logic [0:31] redirect_pc_i,
  output logic        insn_valid_o,
  input  logic        insn_ready_i,
  output logic [0:31] insn_o,
  output logic [0:31] insn_pc_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW = $clog2(READ_LATENCY) + 1;
  localparam int DW = $clog2(READ_LATENCY + BURST_WORDS) + 1;

  // Last value of the latency counter before streaming starts.
  localparam logic [LW-1:0] LAT_LAST = LW'(READ_LATENCY - 2);
  // Highest fill level that still leaves room for a whole burst.
  localparam logic [CW:0]   FILL_MAX = (CW + 1)'(FIFO_DEPTH - BURST_WORDS);

  fetch_state_e  state_q, state_d;
  logic [0:31]   pc_q, pc_d;
  logic [0:31]   addr_q, addr_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [1:0]    beat_q, beat_d;
  logic [DW-1:0] drain_q, drain_d;

  logic          push;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   fill;
  logic          room;
  logic [63:0]   fifo_head;

  // Fill level after this cycle's push (pops are not credited), so a new
  // burst is only started when all four of its words are guaranteed space.
  assign fill = {1'b0, fifo_count} + {{CW{1'b0}}, (state_q == S_STREAM)};
  assign room = (fill <= FILL_MAX);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      lat_q   <= '0;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    lat_d        = lat_q;
    beat_d       = beat_q;
    drain_d      = drain_q;
    push         = 1'b0;
    mem_enable_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (room) state_d = S_REQ;
      end
      S_REQ: begin
        // Suppress the request while redirecting so mainMem never
        // accepts the stale address.
        mem_enable_o = ~redirect_valid_i;
        if (!mem_busy_i && !redirect_valid_i) begin
          state_d = S_WAIT;
          addr_d  = pc_q;
          lat_d   = '0;
        end
      end
      S_WAIT: begin
        mem_enable_o = 1'b1;
        if (lat_q == LAT_LAST) begin
          state_d = S_STREAM;
          beat_d  = 2'd0;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      S_STREAM: begin
        mem_enable_o = 1'b1;
        push         = 1'b1;
        pc_d         = pc_q + 32'd4;
        beat_d       = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = room ? S_REQ : S_IDLE;
      end
      S_DRAIN: begin
        mem_enable_o = 1'b1;
        drain_d      = drain_q - DW'(1);
        if (drain_q == DW'(1)) state_d = S_REQ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (redirect_valid_i) begin
      push = 1'b0;
      pc_d = redirect_pc_i & 32'hFFFF_FFFC;
      case (state_q)
        S_IDLE, S_REQ: state_d = S_REQ;
        S_WAIT: begin
          // Remaining latency cycles plus the whole burst still to come.
          state_d = S_DRAIN;
          drain_d = DW'(LAT_LAST) - DW'(lat_q) + DW'(BURST_WORDS);
        end
        S_STREAM: begin
          // On the last beat the burst is already complete.
          if (beat_q == 2'd3) begin
            state_d = S_REQ;
          end else begin
            state_d = S_DRAIN;
            drain_d = DW'(2'd3 - beat_q);
          end
        end
        default: ;  // DRAIN keeps counting out the burst
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk_i   (clock_i),
    .rst_ni  (reset_n_i),
    .flush_i (redirect_valid_i),
    .push_i  (push),
    .data_i  ({pc_q, mem_data_out_i}),
    .pop_i   (insn_valid_o & insn_ready_i),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign insn_valid_o   = ~fifo_empty;
  assign insn_pc_o      = fifo_head[63:32];
  assign insn_o         = fifo_head[31:0];
  // During REQ the live PC is presented so a redirect re-targets a request
  // held off by mem_busy_i; afterwards the accepted burst address is held.
  assign mem_addr_o     = (state_q == S_REQ) ? pc_q : addr_q;
  assign mem_data_in_o  = '0;
  assign mem_acc_size_o = ACC_4W;
  assign mem_wren_o     = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_insn_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_insn_fetch_unit
// Description : Self-checking bench for insn_fetch_unit with a behavioural
//               mainMem, an expected-stream scoreboard and a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_insn_fetch_unit;

  localparam logic [31:0] BASE = 32'h8002_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;
  logic [1:0]  mem_acc_size;
  logic        mem_wren, mem_enable, mem_busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        insn_valid, insn_ready;
  logic [31:0] insn, insn_pc;

  always #5 clk = ~clk;

  insn_fetch_unit dut (
    .clock_i          (clk),
    .reset_n_i        (rst_n),
    .mem_addr_o       (mem_addr),
    .mem_data_in_o    (mem_data_in),
    .mem_data_out_i   (mem_data_out),
    .mem_acc_size_o   (mem_acc_size),
    .mem_wren_o       (mem_wren),
    .mem_enable_o     (mem_enable),
    .mem_busy_i       (mem_busy),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .insn_valid_o     (insn_valid),
    .insn_ready_i     (insn_ready),
    .insn_o           (insn),
    .insn_pc_o        (insn_pc)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int n_req    = 0;

  logic [63:0] exp_q[$];

  // Program image: word at address a is 55cc55c0 plus its word index from BASE.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h55cc_55c0 + ((a - BASE) >> 2);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // After reset or redirect the decode stream must be the sequential program
  // from the (word-aligned) start address.
  task automatic sb_restart(input logic [31:0] pc);
    logic [31:0] a;
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      a = pc + 32'(4 * i);
      exp_q.push_back({a, word_at(a)});
    end
  endtask

  // ---------------- mainMem model ----------------
  logic        in_burst;
  int          beat;
  logic [31:0] mbase;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_burst     <= 1'b0;
      beat         <= 0;
      mem_data_out <= 32'hBAD0_0000;
    end else if (in_burst) begin
      check("enable_through_burst", mem_enable, 1'b1);
      if (beat < 4) begin
        mem_data_out <= word_at(mbase + 32'(4 * beat));
        beat         <= beat + 1;
      end else begin
        in_burst     <= 1'b0;
        beat         <= 0;
        mem_data_out <= 32'hBAD0_0000 ^ $urandom_range(0, 65535);
      end
    end else if (mem_enable && !mem_busy) begin
      check("req_acc_size", {62'd0, mem_acc_size}, 64'd1);
      check("req_wren", {63'd0, mem_wren}, 64'd0);
      check("req_data_in", {32'd0, mem_data_in}, 64'd0);
      in_burst <= 1'b1;
      beat     <= 0;
      mbase    <= mem_addr;
      n_req++;
    end
  end

  // ---------------- monitor ----------------
  logic        prev_hold = 1'b0;
  logic        prev_redir = 1'b0;
  logic [63:0] prev_out;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold  = 1'b0;
      prev_redir = 1'b0;
    end else begin
      if (prev_redir) check("flush_valid_low", {63'd0, insn_valid}, 64'd0);
      if (prev_hold && !prev_redir) check("hold_stable", {insn_pc, insn}, prev_out);
      if (insn_valid && insn_ready) begin
        check("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) check("insn_stream", {insn_pc, insn}, exp_q.pop_front());
        n_pops++;
      end
      prev_hold  = insn_valid && !insn_ready;
      prev_out   = {insn_pc, insn};
      prev_redir = redirect_valid;
    end
  end

  task automatic wait_valid(input string name, input int bound);
    int n = 0;
    @(negedge clk);
    while (!insn_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'd0, insn_valid}, 64'd1);
  endtask

  task automatic wait_beat(input string name, input int k, input int bound);
    int n = 0;
    @(posedge clk); #1;
    while (!(in_burst && beat == k) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {63'd0, in_burst && beat == k}, 64'd1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    sb_restart(pc & 32'hFFFF_FFFC);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    n_req = 0;
    sb_restart(BASE);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int p0;
    insn_ready = 1'b1; mem_busy = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_enable", {63'd0, mem_enable}, 64'd0);
    check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    check("rst_insn_valid", {63'd0, insn_valid}, 64'd0);
    check("rst_insn", {insn_pc, insn}, 64'd0);

    // First fetch after reset release.
    release_reset();
    @(negedge clk);
    check("idle_after_release", {63'd0, mem_enable}, 64'd0);
    @(negedge clk);
    check("first_req_enable", {63'd0, mem_enable}, 64'd1);
    check("first_req_addr", {32'd0, mem_addr}, {32'd0, BASE});
    check("first_req_size", {62'd0, mem_acc_size}, 64'd1);
    wait_valid("first_valid_timeout", 30);
    check("first_word", {insn_pc, insn}, {BASE, 32'h55cc_55c0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("first_burst_no_gap", {63'd0, insn_valid}, 64'd1);
    end

    // Asynchronous reset in the middle of a burst.
    wait_beat("reset_beat_timeout", 2, 50);
    rst_n = 1'b0;
    #1;
    check("async_rst_enable", {63'd0, mem_enable}, 64'd0);
    check("async_rst_addr", {32'd0, mem_addr}, 64'd0);
    check("async_rst_valid", {63'd0, insn_valid}, 64'd0);
    check("async_rst_insn", {insn_pc, insn}, 64'd0);
    exp_q.delete();

    // Decode stalled: buffer fills with exactly two bursts.
    insn_ready = 1'b0;
    release_reset();
    repeat (20) @(negedge clk);
    check("full_no_request", {63'd0, mem_enable}, 64'd0);
    check("full_burst_count", 64'(n_req), 64'd2);
    check("full_head_word", {insn_pc, insn}, {BASE, 32'h55cc_55c0});
    @(posedge clk); #1;
    insn_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (insn_valid) cnt++;
    end
    check("drain_no_gap", 64'(cnt), 64'd8);

    // mainMem busy at the first request.
    @(posedge clk); #1;
    rst_n = 1'b0;
    mem_busy = 1'b1;
    release_reset();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_addr_held", {31'd0, mem_enable, mem_addr}, {31'd0, 1'b1, BASE});
    end
    check("busy_no_data", {63'd0, insn_valid}, 64'd0);
    @(posedge clk); #1;
    mem_busy = 1'b0;
    wait_valid("busy_valid_timeout", 30);
    check("busy_first_word", {insn_pc, insn}, {BASE, 32'h55cc_55c0});

    // Redirect while the third word of a burst is on the bus.
    wait_beat("redir_beat_timeout", 3, 50);
    do_redirect(32'h8002_0013);
    wait_valid("redir_valid_timeout", 30);
    check("redir_target", {insn_pc, insn}, {32'h8002_0010, 32'h55cc_55c4});

    // Redirect in the same cycle a word is consumed.
    cnt = 0;
    @(posedge clk); #1;
    while (!insn_valid && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("coincident_valid_timeout", {63'd0, insn_valid}, 64'd1);
    p0 = n_pops;
    do_redirect(BASE + 32'h46);
    check("coincident_pop_once", 64'(n_pops - p0), 64'd1);
    wait_valid("coincident_valid2_timeout", 30);
    check("coincident_target", {insn_pc, insn}, {BASE + 32'h44, word_at(BASE + 32'h44)});

    // Randomized traffic with redirects (some near the address wrap).
    p0 = n_pops;
    for (int seg = 0; seg < 14; seg++) begin
      int len;
      len = $urandom_range(20, 120);
      for (int c = 0; c < len; c++) begin
        @(posedge clk); #1;
        insn_ready = ($urandom_range(0, 9) < 7);
        mem_busy   = ($urandom_range(0, 9) < 3);
      end
      if ($urandom_range(0, 3) == 0)
        do_redirect(32'hFFFF_FFE0 + 32'($urandom_range(0, 31)));
      else
        do_redirect(BASE + 32'($urandom_range(0, 255)));
    end
    insn_ready = 1'b1;
    mem_busy   = 1'b0;
    repeat (60) @(posedge clk);
    check("random_progress", {63'd0, n_pops > p0 + 100}, 64'd1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
